// File: rtl/mc_ctrl_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_if
// Control bundle between the multi-cycle MIPS main controller and its
// datapath.
//
//   opcode, funct   IR fields presented to the controller (IR[31:26], IR[5:0])
//   zero            ALU zero flag, consumed while resolving beq
//   PCWrite..ExtOp  datapath control: enables, mux selects, ALU op, extender
//   state           controller state, for debug
//   instr_done      one-cycle pulse in the final state of every instruction
//
// Modports:
//   master  the controller (reads IR fields/flags, drives controls)
//   slave   the datapath   (drives IR fields/flags, reads controls)
// ---------------------------------------------------------------------------
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       ALU_SrcA;
    logic [1:0] ALU_SrcB;
    logic [2:0] ALUOp;
    logic       ExtOp;
    logic [3:0] state;
    logic       instr_done;

    modport master (
        input  opcode, funct, zero,
        output PCWrite, PCSrc, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg,
               ALU_SrcA, ALU_SrcB, ALUOp, ExtOp, state, instr_done
    );

    modport slave (
        output opcode, funct, zero,
        input  PCWrite, PCSrc, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg,
               ALU_SrcA, ALU_SrcB, ALUOp, ExtOp, state, instr_done
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Main controller for the multi-cycle MIPS datapath. A single shared ALU is
// sequenced through fetch / decode / execute / memory / writeback; every
// cycle this FSM drives the ALU operand selects, ALU op, extender mode,
// PC source and all register/memory write enables.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; forces state to FETCH and holds
//              every write enable low while asserted
//   bus        mc_ctrl_if.master: IR fields, zero flag, control outputs
//   cycle_cnt  (MC_PERF_CNT_EN only) non-reset cycle count, wraps
//   instr_cnt  (MC_PERF_CNT_EN only) retired instruction count, wraps
//
// Optional feature macro: MC_PERF_CNT_EN (performance counters).
//
// State table:
//   state  | meaning
//   FETCH  0  | IR <= mem[PC], PC <= PC+4
//   DECODE 1  | read regs, ALUOut <= branch target, pick path
//   MEMADR 2  | ALUOut <= A + sext(imm)
//   MEMRD  3  | MDR <= mem[ALUOut]
//   MEMWB  4  | rt <= MDR
//   MEMWR  5  | mem[ALUOut] <= B
//   RTEXE  6  | ALUOut <= A +/- B
//   ALUWB  7  | rd <= ALUOut
//   BRANCH 8  | compare A,B; PC <= ALUOut if zero
//   IEXE   9  | ALUOut <= A | zext(imm)  or  imm << 16
//   IWB    10 | rt <= ALUOut
//   JUMP   11 | PC <= {PC[31:28], IR[25:0], 00}
//   JAL    12 | as JUMP, and r31 <= PC (already PC+4)
//   JR     13 | PC <= A
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MC_PERF_CNT_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt,
`endif
    mc_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXE   = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic       ext_op;
        logic       done;
    } ctrl_t;

    // Moore decode of the control word for a given state. op/fn select the
    // ALU op in the two execute states that depend on the instruction.
    function automatic ctrl_t ctrl_for(state_t s, logic [5:0] op, logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write = 1'b1;
                c.src_b    = 2'b01;
                c.pc_write = 1'b1;
            end
            S_DECODE: begin
                c.src_b  = 2'b11;
                c.ext_op = 1'b1;
            end
            S_MEMADR: begin
                c.src_a  = 1'b1;
                c.src_b  = 2'b10;
                c.ext_op = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
                c.done       = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.done      = 1'b1;
            end
            S_RTEXE: begin
                c.src_a  = 1'b1;
                c.alu_op = (fn == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b01;
                c.done      = 1'b1;
            end
            S_BRANCH: begin
                // PCWrite here is qualified by zero outside the register.
                c.src_a  = 1'b1;
                c.alu_op = ALU_SUB;
                c.pc_src = 2'b01;
                c.done   = 1'b1;
            end
            S_IEXE: begin
                c.src_a  = 1'b1;
                c.src_b  = 2'b10;
                c.alu_op = (op == OP_LUI) ? ALU_LUI : ALU_OR;
            end
            S_IWB: begin
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            S_JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
                c.done     = 1'b1;
            end
            S_JAL: begin
                c.pc_src     = 2'b10;
                c.pc_write   = 1'b1;
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'b10;
                c.mem_to_reg = 2'b10;
                c.done       = 1'b1;
            end
            S_JR: begin
                c.pc_src   = 2'b11;
                c.pc_write = 1'b1;
                c.done     = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t     state_q;
    state_t     state_nxt;
    ctrl_t      ctrl_q;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic [5:0] op_sel;
    logic [5:0] fn_sel;
    logic       instr_done_w;

    // In DECODE the IR fields are live on the bus; everywhere else the
    // latched copies are used so IR changes cannot redirect the instruction.
    always_comb begin
        op_sel    = (state_q == S_DECODE) ? bus.opcode : op_q;
        fn_sel    = (state_q == S_DECODE) ? bus.funct  : fn_q;
        state_nxt = S_FETCH;
        case (state_q)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:   state_nxt = S_MEMADR;
                    OP_BEQ:         state_nxt = S_BRANCH;
                    OP_ORI, OP_LUI: state_nxt = S_IEXE;
                    OP_J:           state_nxt = S_JUMP;
                    OP_JAL:         state_nxt = S_JAL;
                    OP_RTYPE: begin
                        case (bus.funct)
                            FN_ADDU, FN_SUBU: state_nxt = S_RTEXE;
                            FN_JR:            state_nxt = S_JR;
                            default:          state_nxt = S_FETCH;
                        endcase
                    end
                    default:        state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = S_MEMWB;
            S_RTEXE:  state_nxt = S_ALUWB;
            S_IEXE:   state_nxt = S_IWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state: it is loaded with the
    // decode of the state being entered, so outputs are glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
            ctrl_q  <= ctrl_for(state_t'(RESET_STATE), 6'd0, 6'd0);
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= ctrl_for(state_nxt, op_sel, fn_sel);
            if (state_q == S_DECODE) begin
                op_q <= bus.opcode;
                fn_q <= bus.funct;
            end
        end
    end

    // An unrecognised encoding retires in DECODE itself.
    assign instr_done_w = ctrl_q.done | ((state_q == S_DECODE) && (state_nxt == S_FETCH));

    // Write enables are gated by reset so nothing pulses once reset rises.
    assign bus.PCWrite    = ~reset & (ctrl_q.pc_write | ((state_q == S_BRANCH) & bus.zero));
    assign bus.IRWrite    = ~reset & ctrl_q.ir_write;
    assign bus.MemWrite   = ~reset & ctrl_q.mem_write;
    assign bus.RegWrite   = ~reset & ctrl_q.reg_write;
    assign bus.PCSrc      = ctrl_q.pc_src;
    assign bus.RegDst     = ctrl_q.reg_dst;
    assign bus.MemtoReg   = ctrl_q.mem_to_reg;
    assign bus.ALU_SrcA   = ctrl_q.src_a;
    assign bus.ALU_SrcB   = ctrl_q.src_b;
    assign bus.ALUOp      = ctrl_q.alu_op;
    assign bus.ExtOp      = ctrl_q.ext_op;
    assign bus.state      = state_q;
    assign bus.instr_done = instr_done_w;

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done_w) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Directed bench for mc_ctrl_fsm. Inputs are driven just after the falling
// edge, outputs are sampled on the falling edge (or #1 after an async
// event), expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;
    int   n_fail;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    mc_ctrl_if bus ();

    mc_ctrl_fsm #(.RESET_STATE(4'd0)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MC_PERF_CNT_EN
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        reset      = 1'b1;
        bus.opcode = 6'b000000;
        bus.funct  = 6'b000000;
        bus.zero   = 1'b0;

        // reset held
        nxt();
        chk("rst_state",    32'(bus.state),    32'd0);
        chk("rst_pcwrite",  32'(bus.PCWrite),  32'd0);
        chk("rst_irwrite",  32'(bus.IRWrite),  32'd0);
        chk("rst_srcb",     32'(bus.ALU_SrcB), 32'd1);

        // release: FETCH values visible before the first edge
        reset = 1'b0;
        #1;
        chk("fetch_pcwrite", 32'(bus.PCWrite), 32'd1);
        chk("fetch_irwrite", 32'(bus.IRWrite), 32'd1);
        chk("fetch_srcb",    32'(bus.ALU_SrcB), 32'd1);

        // lw: 0,1,2,3,4
        bus.opcode = 6'b100011;
        nxt();
        chk("lw_s1",        32'(bus.state),    32'd1);
        chk("lw_dec_srcb",  32'(bus.ALU_SrcB), 32'd3);
        chk("lw_dec_ext",   32'(bus.ExtOp),    32'd1);
        chk("lw_dec_pcw",   32'(bus.PCWrite),  32'd0);
        nxt();
        chk("lw_s2",        32'(bus.state),    32'd2);
        chk("lw_adr_srca",  32'(bus.ALU_SrcA), 32'd1);
        chk("lw_adr_srcb",  32'(bus.ALU_SrcB), 32'd2);
        bus.opcode = 6'b101011;   // IR change must not turn lw into sw
        nxt();
        chk("lw_s3",        32'(bus.state),    32'd3);
        chk("lw_rd_regw",   32'(bus.RegWrite), 32'd0);
        chk("lw_rd_done",   32'(bus.instr_done), 32'd0);
        nxt();
        chk("lw_s4",        32'(bus.state),    32'd4);
        chk("lw_wb_regw",   32'(bus.RegWrite), 32'd1);
        chk("lw_wb_m2r",    32'(bus.MemtoReg), 32'd1);
        chk("lw_wb_dst",    32'(bus.RegDst),   32'd0);
        chk("lw_wb_done",   32'(bus.instr_done), 32'd1);
        nxt();
        chk("lw_s0",        32'(bus.state),    32'd0);
        chk("lw_done_off",  32'(bus.instr_done), 32'd0);

        // beq taken
        bus.opcode = 6'b000100;
        bus.zero   = 1'b1;
        nxt();
        nxt();
        chk("beq1_s8",      32'(bus.state),    32'd8);
        chk("beq1_pcw",     32'(bus.PCWrite),  32'd1);
        chk("beq1_pcsrc",   32'(bus.PCSrc),    32'd1);
        chk("beq1_aluop",   32'(bus.ALUOp),    32'd1);
        chk("beq1_done",    32'(bus.instr_done), 32'd1);
        nxt();
        chk("beq1_s0",      32'(bus.state),    32'd0);

        // beq not taken
        bus.zero = 1'b0;
        nxt();
        nxt();
        chk("beq0_s8",      32'(bus.state),    32'd8);
        chk("beq0_pcw",     32'(bus.PCWrite),  32'd0);
        nxt();
        chk("beq0_s0",      32'(bus.state),    32'd0);

        // jal
        bus.opcode = 6'b000011;
        nxt();
        nxt();
        chk("jal_s12",      32'(bus.state),    32'd12);
        chk("jal_dst",      32'(bus.RegDst),   32'd2);
        chk("jal_m2r",      32'(bus.MemtoReg), 32'd2);
        chk("jal_regw",     32'(bus.RegWrite), 32'd1);
        chk("jal_pcsrc",    32'(bus.PCSrc),    32'd2);
        chk("jal_pcw",      32'(bus.PCWrite),  32'd1);
        nxt();

        // ori
        bus.opcode = 6'b001101;
        nxt();
        nxt();
        chk("ori_s9",       32'(bus.state),    32'd9);
        chk("ori_aluop",    32'(bus.ALUOp),    32'd2);
        chk("ori_ext",      32'(bus.ExtOp),    32'd0);
        chk("ori_srcb",     32'(bus.ALU_SrcB), 32'd2);
        nxt();
        chk("ori_s10",      32'(bus.state),    32'd10);
        chk("ori_regw",     32'(bus.RegWrite), 32'd1);
        chk("ori_dst",      32'(bus.RegDst),   32'd0);
        nxt();

        // lui
        bus.opcode = 6'b001111;
        nxt();
        nxt();
        chk("lui_s9",       32'(bus.state),    32'd9);
        chk("lui_aluop",    32'(bus.ALUOp),    32'd3);
        nxt();
        nxt();
        chk("lui_s0",       32'(bus.state),    32'd0);

        // addu / subu
        bus.opcode = 6'b000000;
        bus.funct  = 6'b100001;
        nxt();
        nxt();
        chk("addu_s6",      32'(bus.state),    32'd6);
        chk("addu_aluop",   32'(bus.ALUOp),    32'd0);
        chk("addu_srca",    32'(bus.ALU_SrcA), 32'd1);
        chk("addu_srcb",    32'(bus.ALU_SrcB), 32'd0);
        nxt();
        chk("addu_s7",      32'(bus.state),    32'd7);
        chk("addu_dst",     32'(bus.RegDst),   32'd1);
        chk("addu_regw",    32'(bus.RegWrite), 32'd1);
        nxt();
        bus.funct = 6'b100011;
        nxt();
        nxt();
        chk("subu_s6",      32'(bus.state),    32'd6);
        chk("subu_aluop",   32'(bus.ALUOp),    32'd1);
        nxt();
        nxt();

        // jr
        bus.funct = 6'b001000;
        nxt();
        nxt();
        chk("jr_s13",       32'(bus.state),    32'd13);
        chk("jr_pcsrc",     32'(bus.PCSrc),    32'd3);
        chk("jr_pcw",       32'(bus.PCWrite),  32'd1);
        nxt();

        // illegal: 0 -> 1 -> 0, no writes
        bus.opcode = 6'b111111;
        nxt();
        chk("ill_s1",       32'(bus.state),    32'd1);
        chk("ill_done",     32'(bus.instr_done), 32'd1);
        chk("ill_writes",   {28'd0, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 32'd0);
        nxt();
        chk("ill_s0",       32'(bus.state),    32'd0);

        // sw, aborted by reset in MEMWR
        bus.opcode = 6'b101011;
        nxt();
        nxt();
        nxt();
        chk("sw_s5",        32'(bus.state),    32'd5);
        chk("sw_memw",      32'(bus.MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_memw",   32'(bus.MemWrite), 32'd0);
        chk("abort_state",  32'(bus.state),    32'd0);
        chk("abort_pcw",    32'(bus.PCWrite),  32'd0);
        nxt();
        reset = 1'b0;

        // three j instructions, 9 cycles
        bus.opcode = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            nxt();
            nxt();
            chk($sformatf("j%0d_s11", i),   32'(bus.state),   32'd11);
            chk($sformatf("j%0d_pcsrc", i), 32'(bus.PCSrc),   32'd2);
            chk($sformatf("j%0d_pcw", i),   32'(bus.PCWrite), 32'd1);
            nxt();
        end
        chk("j_end_s0",     32'(bus.state),    32'd0);
`ifdef MC_PERF_CNT_EN
        chk("perf_instr",   instr_cnt,         32'd3);
        chk("perf_cycle",   cycle_cnt,         32'd9);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
